// File: rtl/twiddle_mult_seq_pkg.sv
// Shared FSM state type and fixed-point helpers for the sequential twiddle multiplier.
// Helpers work on a 64-bit carrier so that any DW/TW combination can use them.
package twiddle_pkg;

  localparam int MAXW = 64;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_MUL  = 3'd2,
    ST_SUM  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  function automatic int frac_bits(input int tw);
    return tw - 1;
  endfunction

  function automatic logic signed [MAXW-1:0] round_const(input int frac);
    logic signed [MAXW-1:0] r;
    r = '0;
    if (frac > 0) begin
      r[frac-1] = 1'b1;
    end else begin
      r = '0;
    end
    return r;
  endfunction

  // Round half up, then drop the fractional bits.
  function automatic logic signed [MAXW-1:0] round_shift(input logic signed [MAXW-1:0] v,
                                                         input int frac);
    logic signed [MAXW-1:0] t;
    t = v + round_const(frac);
    return t >>> frac;
  endfunction

  function automatic logic signed [MAXW-1:0] saturate(input  logic signed [MAXW-1:0] v,
                                                      input  int dw,
                                                      output logic sat);
    logic signed [MAXW-1:0] hi;
    logic signed [MAXW-1:0] lo;
    logic signed [MAXW-1:0] r;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (v > hi) begin
      r   = hi;
      sat = 1'b1;
    end else if (v < lo) begin
      r   = lo;
      sat = 1'b1;
    end else begin
      r   = v;
      sat = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/twiddle_mult_seq_if.sv
// Request/result bundle between the twiddle ROM side (master) and the multiplier (slave).
interface twiddle_mult_seq_if #(
  parameter int DW = 8,
  parameter int TW = 8
);
  logic                 i_start;
  logic                 i_inv;
  logic signed [DW-1:0] i_x;
  logic signed [DW-1:0] i_y;
  logic signed [TW-1:0] i_c;
  logic signed [TW-1:0] i_s;
  logic signed [DW-1:0] o_re;
  logic signed [DW-1:0] o_im;
  logic                 o_valid;
  logic                 o_busy;
  logic                 o_sat;

  modport master (
    output i_start, i_inv, i_x, i_y, i_c, i_s,
    input  o_re, o_im, o_valid, o_busy, o_sat
  );

  modport slave (
    input  i_start, i_inv, i_x, i_y, i_c, i_s,
    output o_re, o_im, o_valid, o_busy, o_sat
  );
endinterface

// File: rtl/twiddle_mult_seq_smul.sv
// Signed radix-2 shift-add multiplier: one multiplier bit per cycle, BW cycles after i_start.
// The multiplier MSB carries negative weight, so its partial product is subtracted.
module seq_smul #(
  parameter int AW = 9,
  parameter int BW = 9
) (
  input  logic                    clk,
  input  logic                    i_reset_n,
  input  logic                    i_start,
  input  logic signed [AW-1:0]    i_a,
  input  logic signed [BW-1:0]    i_b,
  output logic signed [AW+BW-1:0] o_p,
  output logic                    o_done
);
  localparam int PW = AW + BW;
  localparam int CW = $clog2(BW + 1);

  logic signed [PW-1:0] acc_q;
  logic signed [PW-1:0] acc_d;
  logic signed [PW-1:0] a_q;
  logic [BW-1:0]        b_q;
  logic [CW-1:0]        cnt_q;
  logic                 run_q;

  // Partial-product accumulate for the current multiplier bit.
  always_comb begin
    acc_d = acc_q;
    if (b_q[0]) begin
      if (cnt_q == '0) begin
        acc_d = acc_q - a_q;
      end else begin
        acc_d = acc_q + a_q;
      end
    end else begin
      acc_d = acc_q;
    end
  end

  // Operand load and per-cycle shift of multiplicand and multiplier.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      acc_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (i_start) begin
      acc_q <= '0;
      a_q   <= {{BW{i_a[AW-1]}}, i_a};
      b_q   <= i_b;
      cnt_q <= CW'(BW - 1);
      run_q <= 1'b1;
    end else if (run_q) begin
      acc_q <= acc_d;
      a_q   <= a_q <<< 1;
      b_q   <= b_q >> 1;
      if (cnt_q == '0) begin
        run_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

  assign o_p    = acc_q;
  assign o_done = run_q && (cnt_q == '0);

endmodule

// File: rtl/twiddle_mult_seq.sv
// Handshaked complex twiddle multiplier (x + jy)(c +/- js) using three sequential multipliers:
// z = c(x-y), Re = y(c-s) + z, Im = x(c+s) - z, rounded half up and saturated to DW bits.
module twiddle_mult_seq
  import twiddle_pkg::*;
#(
  parameter int DW = 8,
  parameter int TW = 8
) (
  input  logic               clk,
  input  logic               i_reset_n,
  twiddle_mult_seq_if.slave  bus
);
  localparam int FRAC = frac_bits(TW);
  localparam int PW   = DW + TW + 2;
  localparam int SW   = DW + TW + 3;
  localparam int CW   = $clog2(TW + 2);

  state_e               state_q;
  logic signed [DW-1:0] x_q, y_q, re_q, im_q;
  logic signed [TW-1:0] c_q;
  logic signed [TW:0]   s_q;
  logic [CW-1:0]        cnt_q;
  logic                 valid_q, busy_q, sat_q;

  logic signed [TW:0]   s_ext_s, s_in_s, c_ext_s, p_s, m_s;
  logic signed [DW:0]   d_s, x_ext_s, y_ext_s;
  logic signed [PW-1:0] z_s, xp_s, ym_s;
  logic [2:0]           done_s;
  logic                 mul_start_s, mul_done_s;
  logic signed [SW-1:0] re_sum_s, im_sum_s;
  logic signed [MAXW-1:0] re_ext_s, im_ext_s, re_lim_s, im_lim_s;
  logic                 re_ovf_s, im_ovf_s;

  // -s is formed at TW+1 bits so that negating the most negative sine stays exact.
  assign s_ext_s = {bus.i_s[TW-1], bus.i_s};
  assign s_in_s  = bus.i_inv ? -s_ext_s : s_ext_s;

  assign c_ext_s = {c_q[TW-1], c_q};
  assign x_ext_s = {x_q[DW-1], x_q};
  assign y_ext_s = {y_q[DW-1], y_q};
  assign d_s     = x_ext_s - y_ext_s;
  assign p_s     = c_ext_s + s_q;
  assign m_s     = c_ext_s - s_q;

  assign mul_start_s = (state_q == ST_LOAD);
  assign mul_done_s  = &done_s;

  seq_smul #(.AW(DW + 1), .BW(TW + 1)) u_mul_z (
    .clk(clk), .i_reset_n(i_reset_n), .i_start(mul_start_s),
    .i_a(d_s), .i_b(c_ext_s), .o_p(z_s), .o_done(done_s[0])
  );
  seq_smul #(.AW(DW + 1), .BW(TW + 1)) u_mul_xp (
    .clk(clk), .i_reset_n(i_reset_n), .i_start(mul_start_s),
    .i_a(x_ext_s), .i_b(p_s), .o_p(xp_s), .o_done(done_s[1])
  );
  seq_smul #(.AW(DW + 1), .BW(TW + 1)) u_mul_ym (
    .clk(clk), .i_reset_n(i_reset_n), .i_start(mul_start_s),
    .i_a(y_ext_s), .i_b(m_s), .o_p(ym_s), .o_done(done_s[2])
  );

  // Final sums, rounding and saturation feeding the result registers.
  always_comb begin
    re_sum_s = {ym_s[PW-1], ym_s} + {z_s[PW-1], z_s};
    im_sum_s = {xp_s[PW-1], xp_s} - {z_s[PW-1], z_s};
    re_ext_s = {{(MAXW - SW){re_sum_s[SW-1]}}, re_sum_s};
    im_ext_s = {{(MAXW - SW){im_sum_s[SW-1]}}, im_sum_s};
    re_ovf_s = 1'b0;
    im_ovf_s = 1'b0;
    re_lim_s = saturate(round_shift(re_ext_s, FRAC), DW, re_ovf_s);
    im_lim_s = saturate(round_shift(im_ext_s, FRAC), DW, im_ovf_s);
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      c_q     <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      re_q    <= '0;
      im_q    <= '0;
      sat_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          valid_q <= 1'b0;
          if (bus.i_start) begin
            x_q     <= bus.i_x;
            y_q     <= bus.i_y;
            c_q     <= bus.i_c;
            s_q     <= s_in_s;
            busy_q  <= 1'b1;
            state_q <= ST_LOAD;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          cnt_q   <= CW'(TW);
          state_q <= ST_MUL;
        end
        ST_MUL: begin
          if (cnt_q == '0) begin
            if (mul_done_s) begin
              state_q <= ST_SUM;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        ST_SUM: begin
          re_q    <= re_lim_s[DW-1:0];
          im_q    <= im_lim_s[DW-1:0];
          sat_q   <= re_ovf_s | im_ovf_s;
          valid_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_DONE;
        end
        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.o_re    = re_q;
  assign bus.o_im    = im_q;
  assign bus.o_sat   = sat_q;
  assign bus.o_valid = valid_q;
  assign bus.o_busy  = busy_q;

endmodule
